// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: shared counts and channel FSM state type for the switch debouncer.
package switch_debouncer_pkg;

   localparam int DEBOUNCE_CNT_DEFAULT = 500000;
   localparam int DEBOUNCE_CNT_SIM     = 4;

   typedef enum logic {IDLE, COUNT} dbc_state_e;

endpackage

// File: rtl/switch_debouncer_debounce_channel.sv
// debounce_channel: one switch bit -- 2-flop synchroniser, bounce filter, level and edge pulses.
// SWITCH_DEBOUNCER_TOGGLE_EN adds a toggle flop that flips on every rising pulse.
module debounce_channel
   import switch_debouncer_pkg::*;
#(
   parameter  int CNT_MAX = DEBOUNCE_CNT_DEFAULT,
   localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic level,
   output logic rise,
   output logic fall
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
   ,
   output logic toggle
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   dbc_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1_q, sync1_d, sync2_q, sync2_d;
   logic             level_q, level_d, rise_q, rise_d, fall_q, fall_d;

   // A disagreement must persist for CNT_MAX consecutive samples; any agreement restarts.
   always_comb begin
      sync1_d = sw_in;
      sync2_d = sync1_q;
      state_d = IDLE;
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (state_q == IDLE) begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
         end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            state_d = COUNT;
            cnt_d   = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
   logic toggle_q, toggle_d;

   always_comb toggle_d = toggle_q ^ rise_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) toggle_q <= 1'b0;
      else        toggle_q <= toggle_d;
   end

   assign toggle = toggle_q;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: NUM_CH independent debounced switch channels plus a combined edge flag.
// SWITCH_DEBOUNCER_TOGGLE_EN adds the SW_TOGGLE output.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int NUM_CH  = 6,
   parameter int CNT_MAX = DEBOUNCE_CNT_DEFAULT
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic [NUM_CH-1:0] SW_IN,
   output logic [NUM_CH-1:0] SW_LEVEL,
   output logic [NUM_CH-1:0] SW_RISE,
   output logic [NUM_CH-1:0] SW_FALL,
   output logic              SW_ANY
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
   ,
   output logic [NUM_CH-1:0] SW_TOGGLE
`endif
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(.CNT_MAX(CNT_MAX)) u_ch (
         .clk    (CLOCK_50),
         .rst_n  (RESET_N),
         .sw_in  (SW_IN[i]),
         .level  (SW_LEVEL[i]),
         .rise   (SW_RISE[i]),
         .fall   (SW_FALL[i])
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
         ,
         .toggle (SW_TOGGLE[i])
`endif
      );
   end

   assign SW_ANY = |(SW_RISE | SW_FALL);

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed plus random stimulus, run-length reference model, queue scoreboard.
module tb_switch_debouncer;
   import switch_debouncer_pkg::*;

   localparam int N   = 6;
   localparam int CNT = DEBOUNCE_CNT_SIM;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] sw_in = '0;
   logic [N-1:0] sw_level, sw_rise, sw_fall;
   logic         sw_any;
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
   logic [N-1:0] sw_toggle;
`endif

   switch_debouncer #(.NUM_CH(N), .CNT_MAX(CNT)) dut (
      .CLOCK_50  (clk),
      .RESET_N   (rst_n),
      .SW_IN     (sw_in),
      .SW_LEVEL  (sw_level),
      .SW_RISE   (sw_rise),
      .SW_FALL   (sw_fall),
      .SW_ANY    (sw_any)
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
      ,
      .SW_TOGGLE (sw_toggle)
`endif
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [N-1:0] level;
      logic [N-1:0] rise;
      logic [N-1:0] fall;
      logic [N-1:0] tog;
      logic         any;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
      end
   endtask

   // Model: a level flips once the two-cycle-delayed input has disagreed with it for CNT samples in a row.
   logic [N-1:0] m_pipe1 = '0, m_pipe2 = '0, m_lvl = '0, m_rise = '0, m_fall = '0, m_tog = '0;
   int           m_run[N];

   initial begin
      foreach (m_run[c]) m_run[c] = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_pipe1 = '0; m_pipe2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_tog = '0;
            foreach (m_run[c]) m_run[c] = 0;
         end else begin
            logic [N-1:0] nr, nf;
            nr = '0;
            nf = '0;
            m_tog = m_tog ^ m_rise;
            for (int c = 0; c < N; c++) begin
               if (m_pipe2[c] != m_lvl[c]) begin
                  m_run[c] = m_run[c] + 1;
                  if (m_run[c] == CNT) begin
                     m_lvl[c] = m_pipe2[c];
                     nr[c]    = m_pipe2[c];
                     nf[c]    = ~m_pipe2[c];
                     m_run[c] = 0;
                  end
               end else m_run[c] = 0;
            end
            m_pipe2 = m_pipe1;
            m_pipe1 = sw_in;
            m_rise  = nr;
            m_fall  = nf;
         end
         q.push_back('{level: m_lvl, rise: m_rise, fall: m_fall, tog: m_tog, any: |(m_rise | m_fall)});
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty at %0t: got 0 entries want 1", $time);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("SW_LEVEL", sw_level, e.level);
            chk("SW_RISE", sw_rise, e.rise);
            chk("SW_FALL", sw_fall, e.fall);
            chk("SW_ANY", {{(N-1){1'b0}}, sw_any}, {{(N-1){1'b0}}, e.any});
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
            chk("SW_TOGGLE", sw_toggle, e.tog);
`endif
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // 1: reset held across both input patterns
      #1 rst_n = 1'b0;
      cyc(3);
      sw_in = '1;
      cyc(3);
      chk("reset_level", sw_level, '0);
      sw_in = '0;
      cyc(2);
      rst_n = 1'b1;
      cyc(3);
      // 2: clean step on channel 0
      sw_in[0] = 1'b1;
      cyc(10);
      // 3: bounce on channel 1, then hold
      for (int k = 0; k < 4; k++) begin
         sw_in[1] = ~k[0];
         cyc(1);
      end
      sw_in[1] = 1'b1;
      cyc(10);
      // 4: glitch shorter than the filter on channel 2
      sw_in[2] = 1'b1;
      cyc(3);
      sw_in[2] = 1'b0;
      cyc(10);
      // 5: coincident rises, then a single fall
      sw_in[4:3] = 2'b11;
      cyc(10);
      sw_in[3] = 1'b0;
      cyc(10);
      // 6: reset mid-count on channel 5, release with the switch up
      sw_in[5] = 1'b1;
      cyc(4);
      rst_n = 1'b0;
      #1;
      chk("async_clear_level", sw_level, '0);
      chk("async_clear_rise", sw_rise | sw_fall, '0);
      cyc(2);
      rst_n = 1'b1;
      cyc(10);
      chk("ch5_level_after_restart", sw_level, sw_in);
`ifdef SWITCH_DEBOUNCER_TOGGLE_EN
      chk("ch5_toggle", {5'b0, sw_toggle[5]}, 6'b000001);
`endif
      // random phase with occasional resets
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < N; c++)
            if ($urandom_range(0, 9) == 0) sw_in[c] = ~sw_in[c];
         rst_n = ($urandom_range(0, 299) != 0);
         cyc(1);
      end
      rst_n = 1'b1;
      cyc(12);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
